exponent_controller: RTL

- Initiator side of the exponent accelerator enable/ready protocol.
- Accepts exponent jobs (x, a, tag) from a host-side valid/ready stream and buffers them in a small FIFO.
- Issues jobs one at a time to exponent_accelerator, then captures each result with its tag and a per-job cycle count.
- Presents each result on a valid/ready output stream. Sits between the system controller/bus and one accelerator instance.

---
 rtl/exponent_controller.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/exponent_controller.sv
// Initiator side of the exponent accelerator enable/ready handshake.
// Host jobs (x, a, tag) are buffered in a small FIFO and issued one at a time.
// Each result is returned with its tag and a cycle count on a valid/ready stream.
module exponent_controller #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [31:0]                req_x,
  input  logic [31:0]                req_a,
  input  logic [TAG_W-1:0]           req_tag,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [31:0]                res_p,
  output logic [TAG_W-1:0]           res_tag,
  output logic [31:0]                res_cycles,
  output logic [$clog2(DEPTH):0]     q_count,
  output logic                       acc_enable,
  output logic [31:0]                acc_x,
  output logic [31:0]                acc_a,
  input  logic                       acc_ready,
  input  logic [31:0]                acc_p
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESULT
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      fifo_x_mem   [DEPTH];
  logic [31:0]      fifo_a_mem   [DEPTH];
  logic [TAG_W-1:0] fifo_tag_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic             push, pop, capture;

  logic             acc_enable_q, res_valid_q;
  logic [31:0]      acc_x_q, acc_a_q, cyc_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      res_p_q, res_cycles_q;
  logic [TAG_W-1:0] res_tag_q;

  // Fullness comes from registered occupancy only, so a same-cycle pop never frees a slot.
  assign req_ready = (count_q != FULL_COUNT);
  assign push      = req_valid && req_ready;

  // Job storage; contents are only meaningful between the pointers, so no reset is needed.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_x_mem[wr_ptr_q]   <= req_x;
      fifo_a_mem[wr_ptr_q]   <= req_a;
      fifo_tag_mem[wr_ptr_q] <= req_tag;
    end
  end

  // FIFO pointers wrap naturally at the power-of-two depth; occupancy tracks push minus pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Next-state logic; pop and capture are the one-cycle events tied to transitions.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && acc_ready) begin
          state_d = S_ISSUE;
          pop     = 1'b1;
        end
      end
      S_ISSUE:     state_d = S_WAIT_BUSY;
      // Ready is high while the accelerator idles; only a fresh rise after a low marks completion.
      S_WAIT_BUSY: if (!acc_ready) state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (acc_ready) begin
          state_d = S_RESULT;
          capture = 1'b1;
        end
      end
      S_RESULT:    if (res_ready) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Registered Moore outputs, operand/tag load on pop, saturating cycle counter, result capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_enable_q <= 1'b0;
      res_valid_q  <= 1'b0;
      acc_x_q      <= '0;
      acc_a_q      <= '0;
      tag_q        <= '0;
      cyc_q        <= '0;
      res_p_q      <= '0;
      res_tag_q    <= '0;
      res_cycles_q <= '0;
    end else begin
      acc_enable_q <= (state_d == S_ISSUE);
      res_valid_q  <= (state_d == S_RESULT);
      if (pop) begin
        acc_x_q <= fifo_x_mem[rd_ptr_q];
        acc_a_q <= fifo_a_mem[rd_ptr_q];
        tag_q   <= fifo_tag_mem[rd_ptr_q];
        cyc_q   <= 32'd1;
      end else if ((state_q inside {S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE}) && (cyc_q != '1)) begin
        cyc_q <= cyc_q + 32'd1;
      end
      if (capture) begin
        res_p_q      <= acc_p;
        res_tag_q    <= tag_q;
        res_cycles_q <= cyc_q;
      end
    end
  end

  assign acc_enable = acc_enable_q;
  assign acc_x      = acc_x_q;
  assign acc_a      = acc_a_q;
  assign res_valid  = res_valid_q;
  assign res_p      = res_p_q;
  assign res_tag    = res_tag_q;
  assign res_cycles = res_cycles_q;
  assign q_count    = count_q;

endmodule
